axi2mem_tcdm_rd_unit: RTL and testbench

AXI2MEM_TCDM_RD_UNIT -- requirements
Module: axi2mem_tcdm_rd_unit

---
 rtl/axi2mem_pkg.sv | 23 ++
 rtl/axi2mem_buffer.sv | 68 ++++++
 rtl/axi2mem_tcdm_rd_unit.sv | 144 ++++++++++++++
 tb/tb_axi2mem_tcdm_rd_unit.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi2mem_pkg.sv
// Shared types and defaults for the axi2mem TCDM read path.
// tcdm_rd_cmd_t  : one queued read command {add, id, last}.
// tcdm_rd_resp_t : one buffered read response {rdata, id, last}.
// The id field is sized to IdWidthMax; users zero-extend narrower IDs into it.
package axi2mem_pkg;

  localparam int unsigned IdWidthMax       = 16;
  localparam int unsigned CmdDepthDefault  = 4;
  localparam int unsigned RespDepthDefault = 4;

  typedef struct packed {
    logic [31:0]           add;
    logic [IdWidthMax-1:0] id;
    logic                  last;
  } tcdm_rd_cmd_t;

  typedef struct packed {
    logic [31:0]           rdata;
    logic [IdWidthMax-1:0] id;
    logic                  last;
  } tcdm_rd_resp_t;

endpackage

// File: rtl/axi2mem_buffer.sv
// Synchronous FIFO with occupancy output.
// Ports: clk_i/rst_ni (async active-low reset), push_i/data_i/full_o (write side),
// pop_i/data_o/empty_o (read side, data_o shows the head), usage_o (entry count).
// Push while full and pop while empty are ignored; simultaneous push/pop keeps occupancy.
module axi2mem_buffer #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  output logic             full_o,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             empty_o,
  output logic [CntW-1:0]  usage_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign usage_o = cnt_q;
  assign data_o  = mem_q[rd_ptr_q];
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d = (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    unique case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/axi2mem_tcdm_rd_unit.sv
// Two-lane TCDM read unit: queues per-lane read commands, issues them to TCDM under a
// response-credit limit, buffers the 1-cycle-latency responses and merges both lanes
// into one 64-bit beat.
// Ports: trans_* (command push per lane, trans_gnt_o = slot free), tcdm_* (TCDM request
// and read response per lane), data_* (merged beat: data_gnt_o = beat available,
// data_req_i = pop). id/last of the merged beat come from lane 0.
module axi2mem_tcdm_rd_unit
  import axi2mem_pkg::*;
#(
  parameter int unsigned CMD_DEPTH  = CmdDepthDefault,
  parameter int unsigned RESP_DEPTH = RespDepthDefault,
  parameter int unsigned ID_WIDTH   = 6
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [1:0]               trans_req_i,
  input  logic [1:0][31:0]         trans_add_i,
  input  logic [1:0][ID_WIDTH-1:0] trans_id_i,
  input  logic [1:0]               trans_last_i,
  output logic [1:0]               trans_gnt_o,
  output logic [1:0]               tcdm_req_o,
  output logic [1:0][31:0]         tcdm_add_o,
  output logic [1:0]               tcdm_wen_o,
  output logic [1:0][3:0]          tcdm_be_o,
  input  logic [1:0]               tcdm_gnt_i,
  input  logic [1:0]               tcdm_r_valid_i,
  input  logic [1:0][31:0]         tcdm_r_rdata_i,
  output logic                     data_gnt_o,
  output logic [63:0]              data_dat_o,
  output logic [ID_WIDTH-1:0]      data_id_o,
  output logic                     data_last_o,
  input  logic                     data_req_i
);

  localparam int unsigned CmdCntW  = $clog2(CMD_DEPTH + 1);
  localparam int unsigned RespCntW = $clog2(RESP_DEPTH + 1);

  tcdm_rd_cmd_t  [1:0]               cmd_in, cmd_head;
  tcdm_rd_resp_t [1:0]               resp_in, resp_head;
  logic          [1:0]               cmd_push, cmd_full, cmd_empty, issue, credit_ok;
  logic          [1:0]               resp_push, resp_full, resp_empty;
  logic          [1:0][CmdCntW-1:0]  cmd_usage;
  logic          [1:0][RespCntW-1:0] resp_usage;
  logic          [1:0]               inflight_q, inflight_d;
  logic          [1:0][IdWidthMax-1:0] slot_id_q, slot_id_d;
  logic          [1:0]               slot_last_q, slot_last_d;
  logic                              beat_pop;

  for (genvar l = 0; l < 2; l++) begin : g_lane
    assign cmd_in[l] = '{add: trans_add_i[l], id: IdWidthMax'(trans_id_i[l]),
                         last: trans_last_i[l]};
    assign trans_gnt_o[l] = ~cmd_full[l];
    assign cmd_push[l]    = trans_req_i[l] & ~cmd_full[l];

    // The in-flight read already owns a response slot, so it counts against the credit.
    assign credit_ok[l]  = (32'(resp_usage[l]) + 32'(inflight_q[l])) < 32'(RESP_DEPTH);
    assign tcdm_req_o[l] = ~cmd_empty[l] & credit_ok[l];
    assign tcdm_add_o[l] = cmd_head[l].add;
    assign tcdm_wen_o[l] = 1'b1;
    assign tcdm_be_o[l]  = 4'hF;
    assign issue[l]      = tcdm_req_o[l] & tcdm_gnt_i[l];

    // A response with nothing in flight is dropped.
    assign resp_push[l] = tcdm_r_valid_i[l] & inflight_q[l];
    assign resp_in[l]   = '{rdata: tcdm_r_rdata_i[l], id: slot_id_q[l], last: slot_last_q[l]};

    axi2mem_buffer #(
      .Width ($bits(tcdm_rd_cmd_t)),
      .Depth (CMD_DEPTH)
    ) u_cmd_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (cmd_push[l]),
      .data_i  (cmd_in[l]),
      .full_o  (cmd_full[l]),
      .pop_i   (issue[l]),
      .data_o  (cmd_head[l]),
      .empty_o (cmd_empty[l]),
      .usage_o (cmd_usage[l])
    );

    axi2mem_buffer #(
      .Width ($bits(tcdm_rd_resp_t)),
      .Depth (RESP_DEPTH)
    ) u_resp_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (resp_push[l]),
      .data_i  (resp_in[l]),
      .full_o  (resp_full[l]),
      .pop_i   (beat_pop),
      .data_o  (resp_head[l]),
      .empty_o (resp_empty[l]),
      .usage_o (resp_usage[l])
    );

    a_no_stray_rvalid : assert property (@(posedge clk_i) disable iff (!rst_ni)
      tcdm_r_valid_i[l] |-> inflight_q[l])
      else $error("tcdm_r_valid_i[%0d] with no read in flight", l);
  end

  // A new grant refills the slot in the same cycle the previous response drains it.
  always_comb begin
    inflight_d  = inflight_q;
    slot_id_d   = slot_id_q;
    slot_last_d = slot_last_q;
    for (int l = 0; l < 2; l++) begin
      if (issue[l]) begin
        inflight_d[l]  = 1'b1;
        slot_id_d[l]   = cmd_head[l].id;
        slot_last_d[l] = cmd_head[l].last;
      end else if (tcdm_r_valid_i[l]) begin
        inflight_d[l] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      inflight_q  <= '0;
      slot_id_q   <= '0;
      slot_last_q <= '0;
    end else begin
      inflight_q  <= inflight_d;
      slot_id_q   <= slot_id_d;
      slot_last_q <= slot_last_d;
    end
  end

  assign data_gnt_o  = ~resp_empty[0] & ~resp_empty[1];
  assign beat_pop    = data_gnt_o & data_req_i;
  assign data_dat_o  = data_gnt_o ? {resp_head[1].rdata, resp_head[0].rdata} : '0;
  assign data_id_o   = data_gnt_o ? resp_head[0].id[ID_WIDTH-1:0] : '0;
  assign data_last_o = data_gnt_o ? resp_head[0].last : 1'b0;

  a_lanes_paired : assert property (@(posedge clk_i) disable iff (!rst_ni)
    data_gnt_o |-> (resp_head[0].id == resp_head[1].id &&
                    resp_head[0].last == resp_head[1].last))
    else $error("merged beat lanes disagree on id/last");

  logic unused_sig;
  assign unused_sig = ^{cmd_usage, resp_full, resp_head[0].id, resp_head[1]};

endmodule

// File: tb/tb_axi2mem_tcdm_rd_unit.sv
module tb_axi2mem_tcdm_rd_unit;

  typedef struct {
    logic [31:0] add;
    logic [5:0]  id;
    logic        last;
  } cmd_t;

  typedef struct {
    logic [63:0] dat;
    logic [5:0]  id;
    logic        last;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [1:0]      trans_req, trans_last, trans_gnt;
  logic [1:0][31:0] trans_add;
  logic [1:0][5:0] trans_id;
  logic [1:0]      tcdm_req, tcdm_wen, tcdm_gnt, r_valid;
  logic [1:0][31:0] tcdm_add, r_rdata;
  logic [1:0][3:0] tcdm_be;
  logic            data_gnt, data_last, data_req;
  logic [63:0]     data_dat;
  logic [5:0]      data_id;

  cmd_t pend[2][$];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   pops  = 0;
  int   issued[2] = '{0, 0};

  always #5 clk = ~clk;

  axi2mem_tcdm_rd_unit #(
    .CMD_DEPTH  (4),
    .RESP_DEPTH (4),
    .ID_WIDTH   (6)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .trans_req_i    (trans_req),
    .trans_add_i    (trans_add),
    .trans_id_i     (trans_id),
    .trans_last_i   (trans_last),
    .trans_gnt_o    (trans_gnt),
    .tcdm_req_o     (tcdm_req),
    .tcdm_add_o     (tcdm_add),
    .tcdm_wen_o     (tcdm_wen),
    .tcdm_be_o      (tcdm_be),
    .tcdm_gnt_i     (tcdm_gnt),
    .tcdm_r_valid_i (r_valid),
    .tcdm_r_rdata_i (r_rdata),
    .data_gnt_o     (data_gnt),
    .data_dat_o     (data_dat),
    .data_id_o      (data_id),
    .data_last_o    (data_last),
    .data_req_i     (data_req)
  );

  function automatic logic [31:0] rdata_of(input logic [31:0] a);
    if (a == 32'h100) return 32'hAAAA0000;
    if (a == 32'h104) return 32'hBBBB0000;
    return {a[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction

  // TCDM memory model: fixed 1-cycle read latency.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
    end else begin
      for (int l = 0; l < 2; l++) begin
        r_valid[l] <= tcdm_req[l] & tcdm_gnt[l];
        r_rdata[l] <= rdata_of(tcdm_add[l]);
        if (tcdm_req[l] && tcdm_gnt[l]) issued[l] <= issued[l] + 1;
      end
    end
  end

  // Command producer: presents each lane's pending head while the DUT is out of reset.
  initial begin
    logic [1:0] acc;
    trans_req  = '0;
    trans_add  = '0;
    trans_id   = '0;
    trans_last = '0;
    forever begin
      @(posedge clk);
      acc = rst_n ? (trans_req & trans_gnt) : 2'b00;
      @(negedge clk);
      for (int l = 0; l < 2; l++) begin
        if (rst_n && acc[l] && pend[l].size() > 0) pend[l].delete(0);
        if (rst_n && pend[l].size() > 0) begin
          trans_req[l]  = 1'b1;
          trans_add[l]  = pend[l][0].add;
          trans_id[l]   = pend[l][0].id;
          trans_last[l] = pend[l][0].last;
        end else begin
          trans_req[l] = 1'b0;
        end
      end
    end
  end

  // Scoreboard consumer: every popped beat is checked against the expected queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && data_gnt && data_req) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL beat_unexpected: got dat=%h id=%0d last=%0b, want no beat",
                   data_dat, data_id, data_last);
        end else begin
          e = sb.pop_front();
          if (data_dat !== e.dat || data_id !== e.id || data_last !== e.last) begin
            n_err++;
            $display("FAIL beat: got dat=%h id=%0d last=%0b, want dat=%h id=%0d last=%0b",
                     data_dat, data_id, data_last, e.dat, e.id, e.last);
          end
        end
        pops++;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic enqueue(input logic [31:0] a0, input logic [31:0] a1, input logic [5:0] id,
                         input logic last);
    cmd_t c0, c1;
    exp_t e;
    c0 = '{add: a0, id: id, last: last};
    c1 = '{add: a1, id: id, last: last};
    pend[0].push_back(c0);
    pend[1].push_back(c1);
    e = '{dat: {rdata_of(a1), rdata_of(a0)}, id: id, last: last};
    sb.push_back(e);
  endtask

  task automatic wait_gnt(input string name);
    for (int i = 0; i < 30 && !data_gnt; i++) tick();
    n_cmp++;
    if (!data_gnt) begin
      n_err++;
      $display("FAIL %s_timeout: data_gnt_o=%0b, want 1 within 30 cycles", name, data_gnt);
    end
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 80 && sb.size() != 0; i++) tick();
    tick();
    n_cmp++;
    if (sb.size() != 0 || data_gnt !== 1'b0) begin
      n_err++;
      $display("FAIL %s_drain: %0d beats left, data_gnt_o=%0b, want 0 left and 0",
               name, sb.size(), data_gnt);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    n_cmp++;
    if (tcdm_req !== 2'b00) begin
      n_err++; $display("FAIL %s_tcdm_req: got %b want 00", name, tcdm_req);
    end
    n_cmp++;
    if (data_gnt !== 1'b0) begin
      n_err++; $display("FAIL %s_data_gnt: got %b want 0", name, data_gnt);
    end
    n_cmp++;
    if (data_dat !== 64'h0) begin
      n_err++; $display("FAIL %s_data_dat: got %h want 0", name, data_dat);
    end
    n_cmp++;
    if (data_id !== 6'd0) begin
      n_err++; $display("FAIL %s_data_id: got %0d want 0", name, data_id);
    end
    n_cmp++;
    if (data_last !== 1'b0) begin
      n_err++; $display("FAIL %s_data_last: got %b want 0", name, data_last);
    end
    n_cmp++;
    if (trans_gnt !== 2'b11) begin
      n_err++; $display("FAIL %s_trans_gnt: got %b want 11", name, trans_gnt);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tcdm_gnt = 2'b11;
    data_req = 1'b0;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (2) tick();
    check_reset_outputs("post_reset");
  endtask

  task automatic test_single_beat();
    tcdm_gnt = 2'b11;
    data_req = 1'b0;
    enqueue(32'h100, 32'h104, 6'd5, 1'b1);
    wait_gnt("single");
    n_cmp++;
    if (data_dat !== 64'hBBBB0000_AAAA0000 || data_id !== 6'd5 || data_last !== 1'b1) begin
      n_err++;
      $display("FAIL single_payload: got dat=%h id=%0d last=%0b, want bbbb0000aaaa0000 5 1",
               data_dat, data_id, data_last);
    end
    data_req = 1'b1;
    tick();
    data_req = 1'b0;
    n_cmp++;
    if (data_gnt !== 1'b0) begin
      n_err++; $display("FAIL single_pop: data_gnt_o=%b want 0 after pop", data_gnt);
    end
  endtask

  task automatic test_stall_burst();
    int b0, b1;
    tcdm_gnt = 2'b11;
    data_req = 1'b0;
    b0 = issued[0];
    b1 = issued[1];
    for (int i = 0; i < 8; i++)
      enqueue(32'h200 + 32'(8 * i), 32'h204 + 32'(8 * i), 6'd3, i == 7);
    repeat (20) tick();
    n_cmp++;
    if (issued[0] - b0 != 4 || issued[1] - b1 != 4) begin
      n_err++;
      $display("FAIL stall_issued: got %0d/%0d reads, want 4/4", issued[0] - b0, issued[1] - b1);
    end
    n_cmp++;
    if (tcdm_req !== 2'b00) begin
      n_err++; $display("FAIL stall_tcdm_req: got %b want 00", tcdm_req);
    end
    n_cmp++;
    if (trans_gnt !== 2'b00) begin
      n_err++; $display("FAIL stall_trans_gnt: got %b want 00", trans_gnt);
    end
    data_req = 1'b1;
    wait_drain("stall");
    data_req = 1'b0;
    n_cmp++;
    if (issued[0] - b0 != 8 || issued[1] - b1 != 8) begin
      n_err++;
      $display("FAIL stall_total: got %0d/%0d reads, want 8/8", issued[0] - b0, issued[1] - b1);
    end
  endtask

  task automatic test_skew();
    int b1;
    tcdm_gnt = 2'b01;
    data_req = 1'b1;
    b1 = issued[1];
    for (int i = 0; i < 3; i++)
      enqueue(32'h400 + 32'(8 * i), 32'h404 + 32'(8 * i), 6'd7, i == 2);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (data_gnt !== 1'b0) begin
        n_err++; $display("FAIL skew_gnt_cycle%0d: got %b want 0", i, data_gnt);
      end
    end
    n_cmp++;
    if (issued[1] != b1) begin
      n_err++; $display("FAIL skew_lane1_idle: got %0d reads want 0", issued[1] - b1);
    end
    tcdm_gnt = 2'b11;
    wait_drain("skew");
    data_req = 1'b0;
  endtask

  task automatic test_back_to_back();
    int busy;
    tcdm_gnt = 2'b11;
    data_req = 1'b1;
    for (int i = 0; i < 16; i++)
      enqueue(32'h800 + 32'(8 * i), 32'h804 + 32'(8 * i), 6'd2, i == 15);
    wait_gnt("b2b");
    busy = 0;
    for (int i = 0; i < 16; i++) begin
      if (data_gnt) busy++;
      tick();
    end
    n_cmp++;
    if (busy != 16) begin
      n_err++; $display("FAIL b2b_throughput: got %0d beat cycles of 16, want 16", busy);
    end
    wait_drain("b2b");
    data_req = 1'b0;
  endtask

  task automatic test_reset_mid();
    int b0, p0;
    tcdm_gnt = 2'b11;
    data_req = 1'b0;
    b0 = issued[0];
    for (int i = 0; i < 4; i++)
      enqueue(32'hC00 + 32'(8 * i), 32'hC04 + 32'(8 * i), 6'd1, i == 3);
    for (int i = 0; i < 30 && issued[0] - b0 < 4; i++) tick();
    n_cmp++;
    if (issued[0] - b0 != 4) begin
      n_err++; $display("FAIL midrst_setup: got %0d reads want 4", issued[0] - b0);
    end
    // Three responses buffered, the fourth read is in flight.
    #1 rst_n = 1'b0;
    pend[0].delete();
    pend[1].delete();
    sb.delete();
    #1 check_reset_outputs("midrst");
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    p0 = pops;
    data_req = 1'b1;
    enqueue(32'h300, 32'h304, 6'd9, 1'b1);
    wait_drain("midrst");
    data_req = 1'b0;
    n_cmp++;
    if (pops - p0 != 1) begin
      n_err++; $display("FAIL midrst_beats: got %0d beats want 1", pops - p0);
    end
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_stall_burst();
    test_skew();
    test_back_to_back();
    test_reset_mid();
    repeat (4) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
